seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter DEAD, default 2, cycles at the start of each slot with all digits off (anti-ghosting); SHALL satisfy 0 <= DEAD < SCAN_DIV.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 load  input  1  request to accept digits_in/blank_mask; honoured only when ready=1.
REQ-007 digits_in  input  16  four 4-bit codes, [3:0]=digit0 … [15:12]=digit3; code 10 = up arrow, 11 = down arrow, 12-15 = blank.
REQ-008 blank_mask  input  4  bit i=1 forces digit i blank regardless of its code.
REQ-009 ready  output  1  high when no update is pending; load is accepted in any cycle with load=1 and ready=1.
REQ-010 an  output  4  active-low digit enables, one-hot-low or all-high.
REQ-011 seg  output  7  active-low segments GFEDCBA for the enabled digit.
REQ-012 frame_start  output  1  one-cycle pulse in the first cycle of digit-0's slot.

Function
REQ-013 A tick counter SHALL count 0..SCAN_DIV-1 and wrap; at count SCAN_DIV-1 the digit index SHALL advance 0->1->2->3->0.
REQ-014 an[idx] SHALL be low when tick >= DEAD and high otherwise; all other an bits high.
REQ-015 seg SHALL be the decode of the active digit's displayed code (0-9 digits, 10 = segments A,B,F, 11 = C,D,E, 12-15 = all off); blank-masked digits decode as all off.
REQ-016 seg and an SHALL be derived from registered state only (no combinational path from load/digits_in).
REQ-017 Accepted load SHALL capture digits_in and blank_mask into a pending register and drive ready low on the next cycle.
REQ-018 load while ready=0 SHALL be ignored; pending contents unchanged.
REQ-019 Pending values SHALL be copied to the display registers on the clock edge where the index wraps 3->0, so a new frame never mixes old and new digits; ready SHALL return high on that same edge.
REQ-020 A load accepted on the wrap edge itself SHALL NOT be applied in that frame; it is applied at the next 3->0 wrap (worst-case latency 4*SCAN_DIV cycles).
REQ-021 frame_start SHALL be high exactly when idx=0 and tick=0.

Reset
REQ-022 On rst: tick=0, idx=0, display codes all 4'hF, blank mask 4'b0000, pending cleared, ready=1.
REQ-023 Resulting outputs: an=4'b1111 if DEAD>0 (else 4'b1110), seg=7'b1111111, frame_start=1.
REQ-024 rst mid-frame or with an update pending SHALL discard the pending update and restart the frame at digit 0.

Structure
REQ-025 Shared package SHALL hold segment/code constants (CODE_UP=10, CODE_DOWN=11, CODE_BLANK=15, SEG_OFF=7'b1111111) and the digit-count constant N_DIG=4.
REQ-026 The code-to-segment decode SHALL be one combinational sub-module, val_to_display, instanced once and fed the muxed active code.
REQ-027 Target size 120-400 lines RTL; no latches, single clock domain.

Verification (SCAN_DIV=4, DEAD=1)
REQ-028 Reset release, no load -> an cycles 1111,1110,1110,1110 then 1111,1101… per slot; seg stays 1111111; frame_start every 16 cycles.
REQ-029 load with digits_in=16'h3210, ready=1, mid-frame -> ready low next cycle; at next frame_start digits 0..3 show 1000000,1111001,0100100,0110000; ready high again.
REQ-030 Second load with 16'h9999 while ready=0 -> ignored; display shows 16'h3210 values.
REQ-031 digits_in=16'hBA00, blank_mask=4'b0010 -> digit0 1000000, digit1 1111111, digit2 1011100, digit3 1100011.
REQ-032 load asserted exactly on the 3->0 wrap edge -> values appear one frame (16 cycles) later, not in the starting frame.
REQ-033 rst asserted with update pending -> ready=1, all digits blank, idx=0 next cycle; pending values never displayed.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the four-digit seven-segment scan controller.
package seg_scan_ctrl_pkg;
    localparam int unsigned N_DIG      = 4;
    localparam logic [3:0]  CODE_UP    = 4'd10;
    localparam logic [3:0]  CODE_DOWN  = 4'd11;
    localparam logic [3:0]  CODE_BLANK = 4'd15;
    localparam logic [6:0]  SEG_OFF    = 7'b1111111;
endpackage

// File: rtl/seg_scan_ctrl_val_to_display.sv
// Combinational code-to-segment decode, active-low GFEDCBA.
module val_to_display
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_OFF;
        case (code)
            4'd0:      seg = 7'b1000000;
            4'd1:      seg = 7'b1111001;
            4'd2:      seg = 7'b0100100;
            4'd3:      seg = 7'b0110000;
            4'd4:      seg = 7'b0011001;
            4'd5:      seg = 7'b0010010;
            4'd6:      seg = 7'b0000010;
            4'd7:      seg = 7'b1111000;
            4'd8:      seg = 7'b0000000;
            4'd9:      seg = 7'b0010000;
            CODE_UP:   seg = 7'b1011100;
            CODE_DOWN: seg = 7'b1100011;
            default:   seg = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed four-digit display scanner with frame-aligned double-buffered updates.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEAD     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  blank_mask,
    output logic        ready,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_start
);
    localparam int unsigned TW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);

    logic [TW-1:0] tick;
    logic [1:0]    idx;
    logic [15:0]   disp_digits;
    logic [3:0]    disp_mask;
    logic [15:0]   pend_digits;
    logic [3:0]    pend_mask;
    logic          pend_valid;
    logic          tick_last;
    logic          frame_wrap;
    logic [3:0]    active_code;

    assign tick_last  = (tick == TICK_LAST);
    assign frame_wrap = tick_last && (idx == 2'(N_DIG - 1));
    assign ready      = ~pend_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick        <= '0;
            idx         <= '0;
            disp_digits <= '1;
            disp_mask   <= '0;
            pend_digits <= '0;
            pend_mask   <= '0;
            pend_valid  <= 1'b0;
        end else begin
            tick <= tick_last ? '0 : tick + TW'(1);
            if (tick_last)
                idx <= idx + 2'd1;
            if (frame_wrap && pend_valid) begin
                disp_digits <= pend_digits;
                disp_mask   <= pend_mask;
                pend_valid  <= 1'b0;
            end
            // Acceptance is gated by the pre-edge ready, so a load landing on
            // the wrap edge is held for the following frame.
            if (load && ready) begin
                pend_digits <= digits_in;
                pend_mask   <= blank_mask;
                pend_valid  <= 1'b1;
            end
        end
    end

    always_comb begin
        an = '1;
        if (tick >= TW'(DEAD))
            an[idx] = 1'b0;
    end

    always_comb begin
        active_code = disp_digits[{idx, 2'b00} +: 4];
        if (disp_mask[idx])
            active_code = CODE_BLANK;
    end

    assign frame_start = (idx == 2'd0) && (tick == '0);

    val_to_display u_dec (
        .code (active_code),
        .seg  (seg)
    );
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench: a frame-position model predicts every cycle's outputs.
module tb_seg_scan_ctrl;
    localparam int SD    = 4;
    localparam int DEADC = 1;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  blank_mask = '0;
    logic        ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_start;

    seg_scan_ctrl #(.SCAN_DIV(SD), .DEAD(DEADC)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .digits_in   (digits_in),
        .blank_mask  (blank_mask),
        .ready       (ready),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [6:0] segtab [16];

    // Model state: cycles since reset, shown digits, pending update.
    int          m_t;
    logic [15:0] m_shown;
    logic [3:0]  m_smask;
    logic        m_pend;
    logic [15:0] m_pdig;
    logic [3:0]  m_pmask;

    function automatic exp_t predict();
        exp_t e;
        int slot, ph;
        logic [3:0] code;
        slot = (m_t / SD) % 4;
        ph   = m_t % SD;
        e.an = 4'hF;
        if (ph >= DEADC) e.an[slot] = 1'b0;
        code = m_shown[slot*4 +: 4];
        if (m_smask[slot]) code = 4'd15;
        e.seg = segtab[code];
        e.fs  = ((m_t % FRAME) == 0);
        e.rdy = !m_pend;
        return e;
    endfunction

    task automatic cycle(input logic r, input logic l, input logic [15:0] d, input logic [3:0] m);
        logic accept;
        rst = r; load = l; digits_in = d; blank_mask = m;
        if (r) begin
            m_t = 0; m_shown = 16'hFFFF; m_smask = 4'h0; m_pend = 1'b0;
        end else begin
            accept = l && !m_pend;
            if ((m_t % FRAME) == FRAME - 1 && m_pend) begin
                m_shown = m_pdig; m_smask = m_pmask; m_pend = 1'b0;
            end
            if (accept) begin
                m_pdig = d; m_pmask = m; m_pend = 1'b1;
            end
            m_t = m_t + 1;
        end
        @(posedge clk);
        #1;
        exp_q.push_back(predict());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom, $urandom);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks += 4;
                if (an !== e.an) begin
                    n_fail++;
                    $display("FAIL an t=%0t got %b want %b", $time, an, e.an);
                end
                if (seg !== e.seg) begin
                    n_fail++;
                    $display("FAIL seg t=%0t got %b want %b", $time, seg, e.seg);
                end
                if (frame_start !== e.fs) begin
                    n_fail++;
                    $display("FAIL frame_start t=%0t got %b want %b", $time, frame_start, e.fs);
                end
                if (ready !== e.rdy) begin
                    n_fail++;
                    $display("FAIL ready t=%0t got %b want %b", $time, ready, e.rdy);
                end
            end
        end
    end

    initial begin
        segtab[0]  = 7'b1000000; segtab[1]  = 7'b1111001;
        segtab[2]  = 7'b0100100; segtab[3]  = 7'b0110000;
        segtab[4]  = 7'b0011001; segtab[5]  = 7'b0010010;
        segtab[6]  = 7'b0000010; segtab[7]  = 7'b1111000;
        segtab[8]  = 7'b0000000; segtab[9]  = 7'b0010000;
        segtab[10] = 7'b1011100; segtab[11] = 7'b1100011;
        for (int i = 12; i < 16; i++) segtab[i] = 7'b1111111;
        m_t = 0; m_shown = 16'hFFFF; m_smask = 4'h0; m_pend = 1'b0;
        m_pdig = '0; m_pmask = '0;

        cycle(1'b1, 1'b0, '0, '0);
        cycle(1'b1, 1'b0, '0, '0);
        idle(34);
        cycle(1'b0, 1'b1, 16'h3210, 4'h0);
        idle(2);
        cycle(1'b0, 1'b1, 16'h9999, 4'h0);
        idle(40);
        cycle(1'b0, 1'b1, 16'hBA00, 4'b0010);
        idle(40);
        while ((m_t % FRAME) != FRAME - 1) idle(1);
        cycle(1'b0, 1'b1, 16'h7654, 4'h0);
        idle(40);
        cycle(1'b0, 1'b1, 16'h8888, 4'h0);
        idle(3);
        cycle(1'b1, 1'b0, '0, '0);
        idle(40);
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), $urandom, $urandom);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d left want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
